// File: rtl/systolic_result_collector.sv
// systolic_result_collector
// Consumer end of the systolic array's result-shift interface. It captures
// one N x N result tile from N parallel lanes over N consecutive cycles, then
// returns the tile through a valid/ready read port, one beat per row.
//
// Build option: define SYSTOLIC_COLLECTOR_TRANSPOSE_EN to return columns
// (C[0][k]..C[N-1][k], column index on rd_row) instead of rows. Capture,
// handshake and timing are the same in both builds.
module systolic_result_collector #(
  parameter int DATA_W = 8,
  parameter int N      = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [DATA_W-1:0]     shift_in_0,
  input  logic [DATA_W-1:0]     shift_in_1,
  input  logic [DATA_W-1:0]     shift_in_2,
  input  logic [DATA_W-1:0]     shift_in_3,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [N*DATA_W-1:0]   rd_data,
  output logic [1:0]            rd_row,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         ptr_q;
  logic [CW-1:0]         ptr_d;
  logic                  rd_valid_q;
  logic [N*DATA_W-1:0]   rd_data_q;
  logic [N*DATA_W-1:0]   rd_data_d;
  logic [CW-1:0]         rd_row_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  overrun_q;

  // Tile storage: buf_q[i][k] holds C[i][k] (lane i, beat k).
  logic [DATA_W-1:0]     buf_q [N][N];
  logic [DATA_W-1:0]     buf_d [N][N];

  logic [DATA_W-1:0]     lane_s [N];
  logic                  capture_s;
  logic [CW-1:0]         col_s;
  logic                  accept_s;
  logic                  drain_next_s;

  assign lane_s[0] = shift_in_0;
  assign lane_s[1] = shift_in_1;
  assign lane_s[2] = shift_in_2;
  assign lane_s[3] = shift_in_3;

  assign accept_s = rd_valid_q && rd_ready;

  // Decide whether this cycle writes a tile column, and which one.
  always_comb begin
    capture_s = 1'b0;
    col_s     = CNT_ZERO;
    if (state_q == ST_IDLE && start) begin
      capture_s = 1'b1;
      col_s     = CNT_ZERO;
    end else if (state_q == ST_CAPTURE) begin
      capture_s = 1'b1;
      col_s     = cnt_q;
    end else begin
      capture_s = 1'b0;
      col_s     = CNT_ZERO;
    end
  end

  // Next tile contents: the current beat lands in column col_s of every lane row.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        buf_d[i][k] = buf_q[i][k];
      end
    end
    if (capture_s) begin
      for (int i = 0; i < N; i++) begin
        buf_d[i][col_s] = lane_s[i];
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        buf_d[i][col_s] = buf_q[i][col_s];
      end
    end
  end

  // Next read pointer and whether the port presents a beat next cycle.
  always_comb begin
    drain_next_s = 1'b0;
    ptr_d        = CNT_ZERO;
    case (state_q)
      ST_CAPTURE: begin
        drain_next_s = (cnt_q == CNT_LAST);
        ptr_d        = CNT_ZERO;
      end
      ST_DRAIN: begin
        if (accept_s) begin
          if (ptr_q == CNT_LAST) begin
            drain_next_s = 1'b0;
            ptr_d        = CNT_ZERO;
          end else begin
            drain_next_s = 1'b1;
            ptr_d        = ptr_q + CNT_ONE;
          end
        end else begin
          drain_next_s = 1'b1;
          ptr_d        = ptr_q;
        end
      end
      default: begin
        drain_next_s = 1'b0;
        ptr_d        = CNT_ZERO;
      end
    endcase
  end

  // Pack the beat addressed by the next pointer; uses buf_d so the beat
  // presented right after the last capture already contains that column.
  always_comb begin
    rd_data_d = {(N*DATA_W){1'b0}};
    for (int j = 0; j < N; j++) begin
`ifdef SYSTOLIC_COLLECTOR_TRANSPOSE_EN
      rd_data_d[j*DATA_W +: DATA_W] = buf_d[j][ptr_d];
`else
      rd_data_d[j*DATA_W +: DATA_W] = buf_d[ptr_d][j];
`endif
    end
  end

  // Tile buffer register; cleared on reset so no stale tile survives an abort.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          buf_q[i][k] <= {DATA_W{1'b0}};
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          buf_q[i][k] <= buf_d[i][k];
        end
      end
    end
  end

  // Control FSM with registered read-port and status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= CNT_ZERO;
      ptr_q      <= CNT_ZERO;
      rd_valid_q <= 1'b0;
      rd_data_q  <= {(N*DATA_W){1'b0}};
      rd_row_q   <= CNT_ZERO;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      ptr_q      <= ptr_d;
      rd_valid_q <= drain_next_s;
      rd_data_q  <= drain_next_s ? rd_data_d : {(N*DATA_W){1'b0}};
      rd_row_q   <= drain_next_s ? ptr_d : CNT_ZERO;
      // A start during an operation is dropped but remembered.
      if (start && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_CAPTURE;
            cnt_q   <= CNT_ONE;
            busy_q  <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_DRAIN;
            cnt_q   <= CNT_ZERO;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        ST_DRAIN: begin
          if (accept_s && (ptr_q == CNT_LAST)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= CNT_ZERO;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_row   = rd_row_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Scoreboard bench for systolic_result_collector. Expected beats are pushed
// when a tile is driven and popped when the read port hands a beat over.
module tb_systolic_result_collector;

  localparam int DATA_W = 8;
  localparam int N      = 4;

  logic                clk;
  logic                rstn;
  logic                start;
  logic [DATA_W-1:0]   shift_in_0;
  logic [DATA_W-1:0]   shift_in_1;
  logic [DATA_W-1:0]   shift_in_2;
  logic [DATA_W-1:0]   shift_in_3;
  logic                rd_valid;
  logic                rd_ready;
  logic [N*DATA_W-1:0] rd_data;
  logic [1:0]          rd_row;
  logic                busy;
  logic                done;
  logic                overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cnt = 0;
  bit bp_mode = 1'b0;

  // Expected beats: {row[1:0], data[31:0]}
  logic [33:0] sb [$];

  // Monitor state
  bit          done_exp   = 1'b0;
  bit          held_valid = 1'b0;
  logic [31:0] held_data;
  logic [1:0]  held_row;

  systolic_result_collector #(.DATA_W(DATA_W), .N(N)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .shift_in_0 (shift_in_0),
    .shift_in_1 (shift_in_1),
    .shift_in_2 (shift_in_2),
    .shift_in_3 (shift_in_3),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_row     (rd_row),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] elem(input int mode, input int i, input int k);
    if (mode == 1) return 8'hFF;
    return 8'(16 * i + k);
  endfunction

  function automatic logic [33:0] exp_beat(input int mode, input int b);
    logic [31:0] d;
    d = 32'h0;
    for (int j = 0; j < N; j++) begin
`ifdef SYSTOLIC_COLLECTOR_TRANSPOSE_EN
      d[j*8 +: 8] = elem(mode, j, b);
`else
      d[j*8 +: 8] = elem(mode, b, j);
`endif
    end
    return {2'(b), d};
  endfunction

  // Advance to just after the next rising edge; drive the backpressure pattern.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bp_mode) rd_ready = ((cyc % 3) == 2);
  endtask

  task automatic set_lanes(input int mode, input int k);
    shift_in_0 = elem(mode, 0, k);
    shift_in_1 = elem(mode, 1, k);
    shift_in_2 = elem(mode, 2, k);
    shift_in_3 = elem(mode, 3, k);
  endtask

  // Drive one tile starting now (just after a rising edge); ovr adds a
  // second start pulse during beat 2. Ends on the falling edge of cycle 4.
  task automatic run_tile(input int mode, input bit ovr);
    for (int b = 0; b < N; b++) sb.push_back(exp_beat(mode, b));
    start = 1'b1;
    set_lanes(mode, 0);
    for (int k = 1; k < N; k++) begin
      step();
      start = (ovr && k == 2);
      set_lanes(mode, k);
    end
    @(negedge clk);
    chk("lat_early", rd_valid, 1'b0);
    step();
    start      = 1'b0;
    shift_in_0 = 8'hA5;
    shift_in_1 = 8'h5A;
    shift_in_2 = 8'hC3;
    shift_in_3 = 8'h3C;
    @(negedge clk);
    chk("lat_first", rd_valid, 1'b1);
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (sb.size() == 0 && !busy && !rd_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_timeout", ok, 1'b1);
    step();
    step();
    chk("sb_empty", sb.size(), 0);
  endtask

  // Read-port monitor: scoreboard compare, hold stability and done timing.
  always @(negedge clk) begin
    logic [33:0] e;
    if (!rstn) begin
      sb.delete();
      done_exp   = 1'b0;
      held_valid = 1'b0;
    end else begin
      chk("done", done, done_exp);
      done_exp = 1'b0;
      if (rd_valid) begin
        if (held_valid) begin
          chk("hold_data", rd_data, held_data);
          chk("hold_row", rd_row, held_row);
        end
        if (rd_ready) begin
          held_valid = 1'b0;
          chk("beat_avail", (sb.size() > 0), 1'b1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("row", rd_row, e[33:32]);
            chk("data", rd_data, e[31:0]);
            acc_cnt++;
            if (e[33:32] == 2'(N - 1)) done_exp = 1'b1;
          end
        end else begin
          held_valid = 1'b1;
          held_data  = rd_data;
          held_row   = rd_row;
        end
      end else begin
        held_valid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc0;
    rstn       = 1'b0;
    start      = 1'b0;
    rd_ready   = 1'b0;
    set_lanes(0, 0);

    // Reset, then idle with no start
    repeat (3) step();
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outs", {rd_valid, busy, done, overrun}, 4'b0000);
    end

    // Basic tile, always ready
    step();
    rd_ready = 1'b1;
    acc0 = acc_cnt;
    run_tile(0, 1'b0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        step();
        if (done) begin
          seen = 1'b1;
          break;
        end
      end
      chk("done_seen", seen, 1'b1);
    end
    chk("basic_beats", acc_cnt - acc0, 4);

    // Start in the cycle done is high: accepted normally
    acc0 = acc_cnt;
    run_tile(1, 1'b0);
    wait_drain();
    chk("b2b_beats", acc_cnt - acc0, 4);
    chk("no_ovr_yet", overrun, 1'b0);

    // Backpressure: ready 0,0,1 repeating
    bp_mode = 1'b1;
    acc0 = acc_cnt;
    step();
    run_tile(0, 1'b0);
    wait_drain();
    chk("bp_beats", acc_cnt - acc0, 4);
    bp_mode  = 1'b0;
    rd_ready = 1'b1;

    // Overrun: second start during capture beat 2
    step();
    run_tile(0, 1'b1);
    wait_drain();
    chk("ovr_set", overrun, 1'b1);
    step();
    run_tile(1, 1'b0);
    wait_drain();
    chk("ovr_sticky", overrun, 1'b1);

    // Reset mid-drain after rows 0 and 1 are accepted
    rd_ready = 1'b0;
    step();
    run_tile(0, 1'b0);
    step();
    rd_ready = 1'b1;
    step();
    step();
    rd_ready = 1'b0;
    chk("pre_rst_row", rd_row, 2'd2);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_async", {rd_valid, busy, done, overrun, rd_data, rd_row}, 38'h0);
    step();
    step();
    rstn = 1'b1;
    chk("rst_ovr_clr", overrun, 1'b0);
    rd_ready = 1'b1;
    acc0 = acc_cnt;
    step();
    run_tile(1, 1'b0);
    wait_drain();
    chk("ff_beats", acc_cnt - acc0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
